morse_player: RTL and testbench

MORSE_PLAYER -- requirements
Module: morse_player

---
 rtl/morse_player_if.sv | 28 ++
 rtl/morse_player.sv | 115 +++++++++++
 tb/tb_morse_player.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/morse_player_if.sv
// Letter request and Morse output bundle between a letter source and morse_player.
// The master side drives the code, length, start and abort; the slave side returns tone and status.
interface morse_player_if #(
   parameter int MAX_LEN = 5
);
   localparam int LW = $clog2(MAX_LEN + 1);

   logic [MAX_LEN-1:0] code_i;
   logic [LW-1:0]      len_i;
   logic               start_i;
   logic               abort_i;
   logic               tone_o;
   logic               dot_o;
   logic               dash_o;
   logic               busy_o;
   logic               done_o;
   logic [LW-1:0]      sym_idx_o;

   modport master (
      output code_i, len_i, start_i, abort_i,
      input  tone_o, dot_o, dash_o, busy_o, done_o, sym_idx_o
   );

   modport slave (
      input  code_i, len_i, start_i, abort_i,
      output tone_o, dot_o, dash_o, busy_o, done_o, sym_idx_o
   );
endinterface

// File: rtl/morse_player.sv
// Plays one Morse letter as timed marks/gaps; tone rises the cycle after a start edge.
// No backpressure: start edges while busy are dropped, abort returns to IDLE next cycle.
module morse_player #(
   parameter int TICKS_PER_UNIT = 25000000,
   parameter int DASH_UNITS     = 3,
   parameter int GAP_UNITS      = 1,
   parameter int MAX_LEN        = 5
) (
   input  logic          CLOCK50_i,
   input  logic          rst_i,
   morse_player_if.slave bus
);
   localparam int LW        = $clog2(MAX_LEN + 1);
   localparam int MAX_UNITS = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
   localparam int MAX_PH    = MAX_UNITS * TICKS_PER_UNIT;
   localparam int PW        = $clog2(MAX_PH + 1);

   localparam logic [PW-1:0] DOT_LAST  = PW'(TICKS_PER_UNIT - 1);
   localparam logic [PW-1:0] DASH_LAST = PW'(DASH_UNITS * TICKS_PER_UNIT - 1);
   localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_UNITS * TICKS_PER_UNIT - 1);
   localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);

   typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      phase_q, phase_d;
   logic [MAX_LEN-1:0] code_q, code_d;
   logic [LW-1:0]      len_q, len_d;
   logic [LW-1:0]      idx_q, idx_d;
   logic               start_prev_q, start_prev_d;

   logic               start_edge;
   logic [LW-1:0]      eff_len;
   logic [MAX_LEN-1:0] code_sh;
   logic               cur_dash;
   logic               last_sym;

   always_comb begin
      start_edge   = bus.start_i & ~start_prev_q;
      eff_len      = (bus.len_i > LEN_MAX) ? LEN_MAX : bus.len_i;
      code_sh      = code_q >> idx_q;
      cur_dash     = code_sh[0];
      last_sym     = (idx_q == (len_q - LW'(1)));

      state_d      = state_q;
      phase_d      = phase_q + PW'(1);
      code_d       = code_q;
      len_d        = len_q;
      idx_d        = idx_q;
      start_prev_d = bus.start_i;

      case (state_q)
         S_IDLE, S_DONE: begin
            phase_d = '0;
            if (start_edge) begin
               code_d  = bus.code_i;
               len_d   = eff_len;
               idx_d   = '0;
               state_d = (eff_len == '0) ? S_DONE : S_MARK;
            end
         end
         S_MARK: begin
            if (bus.abort_i) begin
               state_d = S_IDLE;
               phase_d = '0;
               idx_d   = '0;
            end else if (phase_q == (cur_dash ? DASH_LAST : DOT_LAST)) begin
               phase_d = '0;
               state_d = last_sym ? S_DONE : S_SPACE;
            end
         end
         S_SPACE: begin
            if (bus.abort_i) begin
               state_d = S_IDLE;
               phase_d = '0;
               idx_d   = '0;
            end else if (phase_q == GAP_LAST) begin
               phase_d = '0;
               idx_d   = idx_q + LW'(1);
               state_d = S_MARK;
            end
         end
         default: begin
            state_d = S_IDLE;
            phase_d = '0;
         end
      endcase
   end

   // start_prev resets high so a start held through reset is not seen as an edge
   always_ff @(posedge CLOCK50_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         phase_q      <= '0;
         code_q       <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         start_prev_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         code_q       <= code_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         start_prev_q <= start_prev_d;
      end
   end

   assign bus.tone_o    = (state_q == S_MARK);
   assign bus.dot_o     = (state_q == S_MARK) & ~cur_dash;
   assign bus.dash_o    = (state_q == S_MARK) & cur_dash;
   assign bus.busy_o    = (state_q == S_MARK) | (state_q == S_SPACE);
   assign bus.done_o    = (state_q == S_DONE);
   assign bus.sym_idx_o = idx_q;
endmodule

// File: tb/tb_morse_player.sv
// Scoreboard bench: stimulus queues expected output changes, a negedge monitor checks each change.
module tb_morse_player;
   localparam int TPU = 4;
   localparam int DU  = 3;
   localparam int GU  = 1;
   localparam int ML  = 5;

   typedef struct {
      int         cyc;
      logic [7:0] out;
   } ev_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_bad;
   ev_t  exp_q[$];

   morse_player_if #(.MAX_LEN(ML)) bus ();

   morse_player #(
      .TICKS_PER_UNIT (TPU),
      .DASH_UNITS     (DU),
      .GAP_UNITS      (GU),
      .MAX_LEN        (ML)
   ) dut (
      .CLOCK50_i (clk),
      .rst_i     (rst),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   function automatic logic [7:0] pack_now();
      return {bus.tone_o, bus.dot_o, bus.dash_o, bus.busy_o, bus.done_o, bus.sym_idx_o};
   endfunction

   function automatic logic [7:0] mk(bit t, bit d, bit da, bit b, bit dn, int idx);
      logic [2:0] i3;
      i3 = 3'(idx);
      return {t, d, da, b, dn, i3};
   endfunction

   task automatic push(int c, logic [7:0] o);
      ev_t e;
      e.cyc = c;
      e.out = o;
      exp_q.push_back(e);
   endtask

   task automatic push_mark(int c, bit is_dash, int idx);
      push(c, mk(1'b1, ~is_dash, is_dash, 1'b1, 1'b0, idx));
   endtask

   task automatic push_space(int c, int idx);
      push(c, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, idx));
   endtask

   task automatic push_letter_a(int n);
      push_mark(n + 1, 1'b0, 0);
      push_space(n + 5, 0);
      push_mark(n + 9, 1'b1, 1);
      push(n + 21, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1));
   endtask

   task automatic tick(int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_letter(logic [4:0] code, logic [2:0] len, output int n);
      bus.code_i  = code;
      bus.len_i   = len;
      bus.start_i = 1'b1;
      n = cyc;
   endtask

   task automatic check_direct(string name, logic [7:0] want);
      logic [7:0] got;
      got = pack_now();
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got out=%b, expected out=%b", name, got, want);
      end
   endtask

   // Monitor: every change of the output tuple must match the next queued event
   initial begin
      logic [7:0] prev;
      logic [7:0] cur;
      ev_t        e;
      prev = 8'h00;
      forever begin
         @(negedge clk);
         cur = pack_now();
         if (cur !== prev) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_change: got cyc=%0d out=%b, expected no change", cyc, cur);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || e.out !== cur) begin
                  n_bad++;
                  $display("FAIL output_event: got cyc=%0d out=%b, expected cyc=%0d out=%b",
                           cyc, cur, e.cyc, e.out);
               end
            end
            prev = cur;
         end
      end
   end

   initial begin
      int n;
      n_cmp = 0;
      n_bad = 0;
      rst         = 1'b1;
      bus.code_i  = '0;
      bus.len_i   = '0;
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      tick(3);
      check_direct("reset_state", 8'h00);
      rst = 1'b0;
      tick(2);

      // Letter A, then abort while DONE must change nothing
      start_letter(5'b00010, 3'd2, n);
      push_letter_a(n);
      tick(1);
      bus.start_i = 1'b0;
      tick(25);
      bus.abort_i = 1'b1;
      tick(3);
      bus.abort_i = 1'b0;
      tick(2);

      // Letter 0: five dashes
      start_letter(5'b11111, 3'd5, n);
      for (int k = 0; k < 5; k++) begin
         push_mark(n + 1 + 16 * k, 1'b1, k);
         if (k < 4) push_space(n + 13 + 16 * k, k);
      end
      push(n + 77, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4));
      tick(1);
      bus.start_i = 1'b0;
      tick(80);

      // len 7 clamps to five dots
      start_letter(5'b00000, 3'd7, n);
      for (int k = 0; k < 5; k++) begin
         push_mark(n + 1 + 8 * k, 1'b0, k);
         if (k < 4) push_space(n + 5 + 8 * k, k);
      end
      push(n + 37, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4));
      tick(1);
      bus.start_i = 1'b0;
      tick(40);

      // len 0 goes straight to DONE
      start_letter(5'b00000, 3'd0, n);
      push(n + 1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0));
      tick(1);
      bus.start_i = 1'b0;
      tick(5);

      // Letter A with a start edge during SPACE (ignored) and abort at cycle 10
      start_letter(5'b00010, 3'd2, n);
      push_mark(n + 1, 1'b0, 0);
      push_space(n + 5, 0);
      push_mark(n + 9, 1'b1, 1);
      push(n + 11, 8'h00);
      tick(2);
      bus.start_i = 1'b0;
      tick(4);
      bus.start_i = 1'b1;
      tick(2);
      bus.start_i = 1'b0;
      tick(2);
      bus.abort_i = 1'b1;
      tick(1);
      bus.abort_i = 1'b0;
      tick(10);

      // Reset mid-letter with start held high through release
      start_letter(5'b00010, 3'd2, n);
      push_mark(n + 1, 1'b0, 0);
      push_space(n + 5, 0);
      push(n + 7, 8'h00);
      tick(6);
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(20);
      check_direct("held_start_after_reset", 8'h00);
      bus.start_i = 1'b0;
      tick(2);
      start_letter(5'b00010, 3'd2, n);
      push_letter_a(n);
      tick(1);
      bus.start_i = 1'b0;
      tick(25);

      for (int w = 0; w < 100 && exp_q.size() > 0; w++) tick(1);
      while (exp_q.size() > 0) begin
         ev_t e;
         e = exp_q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missing_event: got nothing, expected cyc=%0d out=%b", e.cyc, e.out);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
